// File: rtl/inst_buffer.sv
// inst_buffer: 2-in/2-out fetch-to-issue FIFO (DEPTH x PAYLOAD_W, flush, stall-aware pop); optional INST_BUF_BYPASS_EN gives 0-cycle empty bypass
module inst_buffer #(
  parameter int DEPTH     = 8,
  parameter int PAYLOAD_W = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic [2*PAYLOAD_W-1:0]   in_data_i,
  input  logic [1:0]               in_valid_i,
  output logic                     in_ready_o,
  output logic [2*PAYLOAD_W-1:0]   out_data_o,
  output logic [1:0]               out_valid_o,
  input  logic [1:0]               issue_num_i,
  input  logic                     stall_i,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [PAYLOAD_W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic [PAYLOAD_W-1:0] lo, hi, c0, w0;
  logic [1:0] in_cnt, push_n, pop_n, vcnt, avail, skip, wr_n;
  logic push, byp;
  assign count_o = count;
  always_comb begin
    lo = in_data_i[PAYLOAD_W-1:0];
    hi = in_data_i[PAYLOAD_W +: PAYLOAD_W];
    c0 = in_valid_i[0] ? lo : hi;
    in_ready_o = count <= (AW+1)'(DEPTH-2);
    push = in_ready_o && |in_valid_i;
    in_cnt = {1'b0, in_valid_i[0]} + {1'b0, in_valid_i[1]};
    push_n = push ? in_cnt : 2'd0;
    avail = count >= (AW+1)'(2) ? 2'd2 : count[1:0];
`ifdef INST_BUF_BYPASS_EN
    byp = count == '0 && !flush_i;
`else
    byp = 1'b0;
`endif
    vcnt = byp ? push_n : avail;
    out_data_o = byp ? {hi, c0} : {mem[rd_ptr + AW'(1)], mem[rd_ptr]};
    out_valid_o = {vcnt[1], |vcnt};
    pop_n = stall_i ? 2'd0 : (issue_num_i > vcnt ? vcnt : issue_num_i);
    skip = byp ? pop_n : 2'd0;
    wr_n = push_n - skip;
    w0 = skip == 2'd0 ? c0 : hi;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(byp ? 2'd0 : pop_n);
      wr_ptr <= wr_ptr + AW'(wr_n);
      count  <= count + (AW+1)'(push_n) - (AW+1)'(pop_n);
    end
  end
  always_ff @(posedge clk) begin
    if (!flush_i && wr_n != 2'd0) mem[wr_ptr] <= w0;
    if (!flush_i && wr_n == 2'd2) mem[wr_ptr + AW'(1)] <= hi;
  end
  issue_legal: assert property (@(posedge clk) disable iff (!rst_n) issue_num_i <= vcnt);
endmodule

// File: tb/tb_inst_buffer.sv
// tb_inst_buffer: directed + queue-model check of inst_buffer
module tb_inst_buffer;
  localparam int DEPTH = 8;
  localparam int PW = 64;
  logic clk = 0, rst_n = 0, flush_i = 0, stall_i = 0;
  logic [2*PW-1:0] in_data_i = '0;
  logic [1:0] in_valid_i = '0, issue_num_i = '0;
  logic in_ready_o;
  logic [2*PW-1:0] out_data_o;
  logic [1:0] out_valid_o;
  logic [$clog2(DEPTH):0] count_o;
  inst_buffer #(.DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_data_i(in_data_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .out_data_o(out_data_o),
    .out_valid_o(out_valid_o), .issue_num_i(issue_num_i), .stall_i(stall_i),
    .count_o(count_o));
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic [PW-1:0] q[$];
  logic [PW-1:0] popped[$];
  logic [PW-1:0] obs_d0, obs_d1;
  logic [1:0] obs_v;
  logic [3:0] obs_c;
  logic obs_r;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step(input logic fl, input logic [1:0] vld, input logic [PW-1:0] d0, input logic [PW-1:0] d1,
                      input logic [1:0] iss, input logic st);
    logic [PW-1:0] in_l[$];
    logic [PW-1:0] view[$];
    int pop, m;
    bit rdy, byp;
    @(negedge clk);
    flush_i = fl; in_valid_i = vld; in_data_i = {d1, d0}; issue_num_i = iss; stall_i = st;
    #1;
    in_l = {};
    if (vld[0]) in_l.push_back(d0);
    if (vld[1]) in_l.push_back(d1);
    rdy = (DEPTH - q.size()) >= 2;
    byp = 0;
`ifdef INST_BUF_BYPASS_EN
    byp = q.size() == 0 && !fl;
`endif
    if (byp) view = in_l; else view = q;
    m = view.size() > 2 ? 2 : view.size();
    chk("count", count_o, q.size());
    chk("ready", in_ready_o, rdy);
    chk("valid", out_valid_o, {m >= 2, m >= 1});
    if (m >= 1) chk("data0", out_data_o[PW-1:0], view[0]);
    if (m >= 2) chk("data1", out_data_o[2*PW-1:PW], view[1]);
    obs_d0 = out_data_o[PW-1:0]; obs_d1 = out_data_o[2*PW-1:PW];
    obs_v = out_valid_o; obs_c = count_o; obs_r = in_ready_o;
    pop = st ? 0 : (iss > m ? m : iss);
    for (int i = 0; i < pop; i++) popped.push_back(out_data_o[i*PW +: PW]);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (rdy) foreach (in_l[i]) q.push_back(in_l[i]);
      repeat (pop) void'(q.pop_front());
    end
  endtask
  task automatic idle(input logic [1:0] iss);
    step(0, 2'b00, '0, '0, iss, 0);
  endtask
  initial begin
    int tag, n, m;
    logic [1:0] v, iss;
    logic [PW-1:0] a, b;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_count", count_o, 0);
    chk("reset_ready", in_ready_o, 1);
    chk("reset_valid", out_valid_o, 2'b00);
    @(negedge clk) rst_n = 1;
    idle(0);
    step(0, 2'b11, 64'hA, 64'hB, 0, 0);
    idle(1);
    chk("ab_valid", obs_v, 2'b11);
    chk("ab_d0", obs_d0, 64'hA);
    chk("ab_d1", obs_d1, 64'hB);
    chk("ab_count", obs_c, 2);
    idle(0);
    chk("pop1_d0", obs_d0, 64'hB);
    chk("pop1_valid", obs_v, 2'b01);
    chk("pop1_count", obs_c, 1);
    idle(1);
    step(0, 2'b10, 64'h0, 64'hC, 0, 0);
    idle(1);
    chk("slot1_d0", obs_d0, 64'hC);
    chk("slot1_count", obs_c, 1);
    for (int i = 0; i < 3; i++) step(0, 2'b11, 64'h100 + 2*i, 64'h101 + 2*i, 0, 0);
    step(0, 2'b01, 64'h106, 64'h0, 0, 0);
    idle(0);
    chk("full7_count", obs_c, 7);
    chk("full7_ready", obs_r, 0);
    step(0, 2'b11, 64'hDEAD, 64'hBEEF, 0, 0);
    step(0, 2'b11, 64'hDEAD, 64'hBEEF, 2, 0);
    chk("full7_hold", obs_c, 7);
    idle(0);
    chk("after_pop_count", obs_c, 5);
    chk("after_pop_ready", obs_r, 1);
    chk("after_pop_head", obs_d0, 64'h102);
    idle(2); idle(2); idle(1);
    step(0, 2'b11, 64'h200, 64'h201, 0, 0);
    step(0, 2'b01, 64'h202, 64'h0, 0, 0);
    step(0, 2'b00, '0, '0, 2, 1);
    idle(0);
    chk("stall_count", obs_c, 3);
    chk("stall_head", obs_d0, 64'h200);
    step(0, 2'b11, 64'h203, 64'h204, 0, 0);
    step(1, 2'b11, 64'h300, 64'h301, 2, 0);
    chk("preflush_count", obs_c, 5);
    idle(0);
    chk("flush_count", obs_c, 0);
    chk("flush_valid", obs_v, 2'b00);
    chk("flush_ready", obs_r, 1);
    popped.delete();
    tag = 0;
    for (int cyc = 0; cyc < 300 && popped.size() < 20; cyc++) begin
      n = 20 - tag;
      v = n >= 2 ? 2'($urandom_range(1, 3)) : n == 1 ? ($urandom_range(0, 1) ? 2'b01 : 2'b10) : 2'b00;
      a = PW'(tag);
      b = v == 2'b11 ? PW'(tag + 1) : PW'(tag);
      if (q.size() <= DEPTH - 2) tag += int'(v[0]) + int'(v[1]);
      m = q.size() > 2 ? 2 : q.size();
      iss = 2'($urandom_range(0, m));
      step(0, v, a, b, iss, $urandom_range(0, 3) == 0);
    end
    chk("wrap_popped", popped.size(), 20);
    foreach (popped[i]) chk("wrap_order", popped[i], i);
    while (q.size() > 0) idle(q.size() > 1 ? 2'd2 : 2'd1);
`ifdef INST_BUF_BYPASS_EN
    step(0, 2'b11, 64'hD, 64'hE, 1, 0);
    chk("byp_d0_same_cycle", obs_d0, 64'hD);
    idle(0);
    chk("byp_next_d0", obs_d0, 64'hE);
    chk("byp_next_count", obs_c, 1);
    idle(1);
`endif
    step(0, 2'b11, 64'h400, 64'h401, 0, 0);
    step(0, 2'b11, 64'h402, 64'h403, 0, 0);
    @(negedge clk);
    in_valid_i = 0; issue_num_i = 0; flush_i = 0; stall_i = 0;
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("midrst_count", count_o, 0);
    chk("midrst_valid", out_valid_o, 2'b00);
    chk("midrst_ready", in_ready_o, 1);
    q.delete();
    @(negedge clk) rst_n = 1;
    idle(0);
    step(0, 2'b01, 64'h500, 64'h0, 0, 0);
    idle(0);
    chk("post_rst_d0", obs_d0, 64'h500);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
